// File: rtl/if_fetch_if.sv
// if_fetch_if: simplified AXI read-address/read-data channel pair between fetch (master) and memory (slave)
// ar_valid/ar_ready/ar_addr: single-beat read request; r_valid/r_ready/r_data/r_resp: read data beat and response
interface if_fetch_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              ar_valid;
  logic              ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic              r_valid;
  logic              r_ready;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  modport master (output ar_valid, ar_addr, r_ready, input ar_ready, r_valid, r_data, r_resp);
  modport slave  (input ar_valid, ar_addr, r_ready, output ar_ready, r_valid, r_data, r_resp);
endinterface

// File: rtl/if_fetch.sv
// if_fetch: RV64 instruction fetch; owns the PC, issues single-beat AXI reads, hands 32-bit words to decode
// clk/rst_n: clock and synchronous active-low reset; redirect_valid/redirect_pc: new PC from execute/CSR
// bus: AXI AR/R master; inst_valid/id_ready: decode handshake; inst/inst_pc/fetch_err: instruction, its PC, bus fault
module if_fetch #(
  parameter int                ADDR_W   = 64,
  parameter int                DATA_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  if_fetch_if.master        bus,
  output logic              inst_valid,
  input  logic              id_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              fetch_err
);
  typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_R, ST_HOLD} state_t;
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt, addr;
  logic              kill, kill_nxt, take;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      kill      <= 1'b0;
      addr      <= {RESET_PC[ADDR_W-1:3], 3'b0};
      inst      <= '0;
      inst_pc   <= '0;
      fetch_err <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      kill  <= kill_nxt;
      // address is latched on entry to AR so a redirect cannot disturb a pending request
      if (state_nxt == ST_AR && state != ST_AR) addr <= {pc_nxt[ADDR_W-1:3], 3'b0};
      if (take) begin
        inst      <= pc[2] ? bus.r_data[DATA_W-1:32] : bus.r_data[31:0];
        inst_pc   <= pc;
        fetch_err <= |bus.r_resp;
      end
    end
  end
  always_comb begin
    take      = state == ST_R && bus.r_valid && !kill && !redirect_valid;
    state_nxt = state == ST_IDLE ? ST_AR
              : state == ST_AR   ? (bus.ar_ready ? ST_R : ST_AR)
              : state == ST_R    ? (!bus.r_valid ? ST_R : take ? ST_HOLD : ST_AR)
              : (redirect_valid || id_ready) ? ST_AR : ST_HOLD;
    pc_nxt    = redirect_valid ? redirect_pc : take ? pc + ADDR_W'(4) : pc;
    // a redirect with a read outstanding marks the returning beat as stale
    kill_nxt  = redirect_valid ? (state == ST_AR || (state == ST_R && !bus.r_valid))
              : (state == ST_R && bus.r_valid) ? 1'b0 : kill;
  end
  always_comb begin
    bus.ar_valid = state == ST_AR;
    bus.ar_addr  = addr;
    bus.r_ready  = state == ST_R;
    inst_valid   = state == ST_HOLD;
  end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed plus randomized check of if_fetch against an instruction-stream model
module tb_if_fetch;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        id_ready = 1'b0;
  logic        inst_valid, fetch_err;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  int          checks = 0, failures = 0, delivered = 0, ar_pct = 100, r_pct = 100;
  logic [63:0] model_pc = RESET_PC, exp_ar = '0;
  logic [63:0] pend_q[$];
  if_fetch_if bus ();
  if_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .bus(bus), .inst_valid(inst_valid), .id_ready(id_ready), .inst(inst), .inst_pc(inst_pc),
    .fetch_err(fetch_err)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] mem(input logic [63:0] a);
    return a == 64'h8000_0000 ? 64'h00000013_00100093 : {a[31:0] ^ 32'h1357_9bdf, ~a[31:0] ^ 32'h0f0f_1111};
  endfunction
  function automatic logic [1:0] resp(input logic [63:0] a);
    return a[6:3] == 4'd11 ? 2'b10 : 2'b00;
  endfunction
  function automatic logic [31:0] word(input logic [63:0] pc);
    logic [63:0] d;
    d = mem({pc[63:3], 3'b0});
    return pc[2] ? d[63:32] : d[31:0];
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    logic        p_rst, p_redir, p_iv, p_idr, p_arv, p_arr, p_rv, p_rr;
    logic [63:0] p_rpc, p_addr;
    p_rst = rst_n; p_redir = redirect_valid; p_rpc = redirect_pc; p_iv = inst_valid; p_idr = id_ready;
    p_arv = bus.ar_valid; p_arr = bus.ar_ready; p_addr = bus.ar_addr; p_rv = bus.r_valid; p_rr = bus.r_ready;
    @(posedge clk);
    #1;
    if (!p_rst) begin
      model_pc = RESET_PC;
      pend_q.delete();
      bus.r_valid = 1'b0;
      chk("rst_ar_valid", bus.ar_valid, 0);
      chk("rst_r_ready", bus.r_ready, 0);
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_inst", inst, 0);
      chk("rst_inst_pc", inst_pc, 0);
      chk("rst_fetch_err", fetch_err, 0);
    end else begin
      if (p_redir) begin
        model_pc = p_rpc;
        chk("redirect_flush", inst_valid, 0);
      end
      if (p_arv && p_arr) begin
        pend_q.push_back(p_addr);
        chk("ar_drop_after_hs", bus.ar_valid, 0);
      end
      if (p_rv && p_rr) begin
        if (pend_q.size() > 0) void'(pend_q.pop_front());
        bus.r_valid = 1'b0;
      end
      if (bus.ar_valid && !p_arv) begin
        exp_ar = {model_pc[63:3], 3'b0};
        chk("ar_addr_new", bus.ar_addr, exp_ar);
      end
      if (p_arv && !p_arr) begin
        chk("ar_hold_valid", bus.ar_valid, 1);
        chk("ar_hold_addr", bus.ar_addr, exp_ar);
      end
      if (p_iv && !p_idr && !p_redir) begin
        chk("hold_valid", inst_valid, 1);
        chk("hold_pc", inst_pc, model_pc - 64'd4);
        chk("hold_inst", inst, word(model_pc - 64'd4));
        chk("hold_err", fetch_err, resp({model_pc[63:3] - 61'(model_pc[2] ? 0 : 1), 3'b0}) != 0);
      end
      if (p_iv && p_idr) chk("no_duplicate", inst_valid, 0);
      if (inst_valid && !p_iv) begin
        chk("sb_pc", inst_pc, model_pc);
        chk("sb_inst", inst, word(model_pc));
        chk("sb_err", fetch_err, resp({model_pc[63:3], 3'b0}) != 0);
        model_pc += 64'd4;
        delivered++;
      end
    end
    bus.ar_ready = $urandom_range(1, 100) <= ar_pct;
    if (!bus.r_valid && pend_q.size() > 0 && $urandom_range(1, 100) <= r_pct) begin
      bus.r_valid = 1'b1;
      bus.r_data  = mem(pend_q[0]);
      bus.r_resp  = resp(pend_q[0]);
    end
  endtask
  task automatic expect_inst(input string tag, input logic [63:0] epc, input logic [31:0] ei);
    for (int i = 0; i < 30 && !inst_valid; i++) step();
    chk({tag, "_valid"}, inst_valid, 1);
    chk({tag, "_pc"}, inst_pc, epc);
    chk({tag, "_inst"}, inst, ei);
  endtask
  task automatic wait_ar(input string tag, input logic [63:0] a);
    for (int i = 0; i < 30 && !(bus.ar_valid && bus.ar_addr == a); i++) step();
    chk({tag, "_valid"}, bus.ar_valid, 1);
    chk({tag, "_addr"}, bus.ar_addr, a);
  endtask
  initial begin
    bus.ar_ready = 1'b0; bus.r_valid = 1'b0; bus.r_data = '0; bus.r_resp = '0;
    id_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("first_ar_valid", bus.ar_valid, 1);
    chk("first_ar_addr", bus.ar_addr, 64'h8000_0000);
    expect_inst("i0", 64'h8000_0000, 32'h0010_0093);
    step();
    chk("i1_ar_valid", bus.ar_valid, 1);
    chk("i1_ar_addr", bus.ar_addr, 64'h8000_0000);
    expect_inst("i1", 64'h8000_0004, 32'h0000_0013);
    id_ready = 1'b0;
    repeat (5) begin
      step();
      chk("bp_valid", inst_valid, 1);
      chk("bp_inst", inst, 32'h0000_0013);
      chk("bp_pc", inst_pc, 64'h8000_0004);
      chk("bp_ar_valid", bus.ar_valid, 0);
    end
    id_ready = 1'b1;
    step();
    chk("bp_rel_valid", inst_valid, 0);
    chk("bp_rel_ar_valid", bus.ar_valid, 1);
    chk("bp_rel_ar_addr", bus.ar_addr, 64'h8000_0008);
    r_pct = 0;
    step();
    chk("in_r", bus.r_ready, 1);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    r_pct = 100;
    step();
    step();
    chk("rdr_drop_valid", inst_valid, 0);
    chk("rdr_ar_valid", bus.ar_valid, 1);
    chk("rdr_ar_addr", bus.ar_addr, 64'h8000_1000);
    expect_inst("rdr", 64'h8000_1000, word(64'h8000_1000));
    ar_pct = 0;
    step();
    chk("rda_ar_valid", bus.ar_valid, 1);
    chk("rda_ar_addr", bus.ar_addr, 64'h8000_1000);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
    step();
    redirect_valid = 1'b0;
    repeat (3) begin
      chk("rda_old_valid", bus.ar_valid, 1);
      chk("rda_old_addr", bus.ar_addr, 64'h8000_1000);
      step();
    end
    ar_pct = 100;
    wait_ar("rda_target", 64'h8000_2000);
    expect_inst("rda", 64'h8000_2000, word(64'h8000_2000));
    redirect_valid = 1'b1; redirect_pc = 64'h8000_3000;
    step();
    redirect_valid = 1'b0;
    chk("rdh_valid", inst_valid, 0);
    chk("rdh_ar_valid", bus.ar_valid, 1);
    chk("rdh_ar_addr", bus.ar_addr, 64'h8000_3000);
    expect_inst("rdh", 64'h8000_3000, word(64'h8000_3000));
    step();
    chk("rdh_no_dup", inst_valid, 0);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0058;
    step();
    redirect_valid = 1'b0;
    expect_inst("err", 64'h8000_0058, word(64'h8000_0058));
    chk("err_flag", fetch_err, 1);
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    expect_inst("wrap_hi", 64'hFFFF_FFFF_FFFF_FFFC, word(64'hFFFF_FFFF_FFFF_FFFC));
    chk("wrap_hi_err", fetch_err, 0);
    step();
    chk("wrap_ar_valid", bus.ar_valid, 1);
    chk("wrap_ar_addr", bus.ar_addr, 64'h0);
    expect_inst("wrap_lo", 64'h0, word(64'h0));
    r_pct = 0;
    for (int i = 0; i < 10 && !bus.r_ready; i++) step();
    chk("mid_r", bus.r_ready, 1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_ar_valid", bus.ar_valid, 0);
    chk("mid_rst_r_ready", bus.r_ready, 0);
    chk("mid_rst_inst_valid", inst_valid, 0);
    chk("mid_rst_inst_pc", inst_pc, 0);
    rst_n = 1'b1; r_pct = 100;
    step();
    chk("rerun_ar_valid", bus.ar_valid, 1);
    chk("rerun_ar_addr", bus.ar_addr, 64'h8000_0000);
    ar_pct = $urandom_range(30, 100);
    r_pct  = $urandom_range(30, 100);
    for (int i = 0; i < 3000; i++) begin
      id_ready       = $urandom_range(0, 3) != 0;
      redirect_valid = $urandom_range(0, 19) == 0;
      redirect_pc    = 64'h8000_0000 + 64'($urandom_range(0, 511)) * 64'd4;
      step();
    end
    redirect_valid = 1'b0;
    chk("rand_progress", 64'(delivered > 100), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
